// File: rtl/arith_dispatch.sv
// Issue-side dispatcher between decode and the arithmetic unit: one request in flight, operands held
// for the unit, result returned on a valid/ready writeback port. Optional WAIT timeout: ARITH_DISPATCH_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a request from decode
// START   | one-cycle start pulse to the unit
// WAIT    | operands held, waiting for the unit's valid
// CAPTURE | result registered; rd==0 drops the write
// WB      | writeback presented until the register file accepts
module arith_dispatch #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_req_op,
  input  logic [1:0]      i_req_func,
  input  logic [XLEN-1:0] i_req_rs1,
  input  logic [XLEN-1:0] i_req_rs2,
  input  logic [4:0]      i_req_rd,
  output logic            o_au_start,
  output logic [2:0]      o_au_op,
  output logic [1:0]      o_au_func,
  output logic [XLEN-1:0] o_au_rs1,
  output logic [XLEN-1:0] o_au_rs2,
  input  logic            i_au_valid,
  input  logic [XLEN-1:0] i_au_result,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_busy,
  output logic            o_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_WB      = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [1:0]      func_q;
  logic [XLEN-1:0] rs1_q, rs2_q, result_q;
  logic [4:0]      rd_q;
  logic            timeout;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("arith_dispatch: TIMEOUT_CYCLES must be within 2..255");
  end

`ifdef ARITH_DISPATCH_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;

  // Fires on the last allowed WAIT cycle so WAIT lasts exactly TIMEOUT_CYCLES cycles.
  assign timeout = (state == S_WAIT) && !i_au_valid && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign o_err   = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_START)
        wait_cnt <= '0;
      else if (state == S_WAIT && !i_au_valid)
        wait_cnt <= wait_cnt + 8'd1;
      if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      func_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && i_req_valid) begin
        op_q   <= i_req_op;
        func_q <= i_req_func;
        rs1_q  <= i_req_rs1;
        rs2_q  <= i_req_rs2;
        rd_q   <= i_req_rd;
      end
      if (state == S_CAPTURE)
        result_q <= i_au_result;
    end
  end

  always_comb begin
    state_nxt   = state;
    o_req_ready = 1'b0;
    o_au_start  = 1'b0;
    o_wb_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nxt = S_START;
      end
      S_START: begin
        o_au_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (i_au_valid)   state_nxt = S_CAPTURE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_CAPTURE: state_nxt = (rd_q == 5'd0) ? S_IDLE : S_WB;
      S_WB: begin
        o_wb_valid = 1'b1;
        if (i_wb_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_au_op   = op_q;
  assign o_au_func = func_q;
  assign o_au_rs1  = rs1_q;
  assign o_au_rs2  = rs2_q;
  assign o_wb_rd   = rd_q;
  assign o_wb_data = result_q;
  assign o_busy    = (state != S_IDLE);

endmodule

// File: tb/tb_arith_dispatch.sv
// Scoreboard bench for arith_dispatch: directed cycle checks plus randomized ADD/SUB traffic
// against a plain-arithmetic model, with a behavioural arithmetic unit and random writeback backpressure.
module tb_arith_dispatch;
  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_req_valid;
  logic            o_req_ready;
  logic [2:0]      i_req_op;
  logic [1:0]      i_req_func;
  logic [XLEN-1:0] i_req_rs1, i_req_rs2;
  logic [4:0]      i_req_rd;
  logic            o_au_start;
  logic [2:0]      o_au_op;
  logic [1:0]      o_au_func;
  logic [XLEN-1:0] o_au_rs1, o_au_rs2;
  logic            i_au_valid;
  logic [XLEN-1:0] i_au_result;
  logic            o_wb_valid;
  logic            i_wb_ready;
  logic [4:0]      o_wb_rd;
  logic [XLEN-1:0] o_wb_data;
  logic            o_busy;
  logic            o_err;

  arith_dispatch #(.XLEN(XLEN), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_func(i_req_func),
    .i_req_rs1(i_req_rs1), .i_req_rs2(i_req_rs2), .i_req_rd(i_req_rd),
    .o_au_start(o_au_start), .o_au_op(o_au_op), .o_au_func(o_au_func),
    .o_au_rs1(o_au_rs1), .o_au_rs2(o_au_rs2),
    .i_au_valid(i_au_valid), .i_au_result(i_au_result),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  au_lat = 0;
  bit  wb_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[0] ? (a - b) : (a + b);
  endfunction

  // Behavioural unit: answers only ADD-class ops, au_lat extra cycles after the start pulse,
  // and keeps its result on the bus until the next operation.
  initial begin
    logic [31:0] r;
    i_au_valid  = 1'b0;
    i_au_result = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_au_start && o_au_op == 3'b000) begin
        r = o_au_func[0] ? (o_au_rs1 - o_au_rs2) : (o_au_rs1 + o_au_rs2);
        repeat (au_lat) @(posedge i_clk);
        @(posedge i_clk);
        #1 i_au_valid = 1'b1;
        i_au_result = r;
        @(posedge i_clk);
        #1 i_au_valid = 1'b0;
      end
    end
  end

  always @(posedge i_clk) begin
    if (wb_rand) begin
      #1 i_wb_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every presented writeback must match the scoreboard head; pop on acceptance.
  initial begin
    wb_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got rd=%0d data=%h with no write outstanding", o_wb_rd, o_wb_data);
        end else begin
          e = exp_q[0];
          chk("wb_rd", 32'(o_wb_rd), 32'(e.rd));
          chk("wb_data", o_wb_data, e.data);
          if (i_wb_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // Returns at the negedge of cycle 1 (START), after checking the start pulse and operands.
  task automatic send(input logic [2:0] op, input logic [1:0] func, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd);
    bit ok;
    wb_t e;
    ok = 1'b0;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_func  = func;
    i_req_rs1   = a;
    i_req_rs2   = b;
    i_req_rd    = rd;
    for (int n = 0; n < 300; n++) begin
      @(negedge i_clk);
      if (o_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_accept: got ready=0 required ready=1 within 300 cycles");
    end else if (rd != 5'd0 && op == 3'b000) begin
      e.rd   = rd;
      e.data = model(func, a, b);
      exp_q.push_back(e);
    end
    @(negedge i_clk);
    chk("au_start", 32'(o_au_start), 32'd1);
    chk("au_op", 32'(o_au_op), 32'(op));
    chk("au_func", 32'(o_au_func), 32'(func));
    chk("au_rs1", o_au_rs1, a);
    chk("au_rs2", o_au_rs2, b);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (o_busy && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    if (o_busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy=1 required busy=0 within %0d cycles", limit);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
    chk({tag, "_au_start"}, 32'(o_au_start), 32'd0);
    chk({tag, "_wb_valid"}, 32'(o_wb_valid), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_au_op"}, 32'(o_au_op), 32'd0);
    chk({tag, "_au_rs1"}, o_au_rs1, 32'd0);
    chk({tag, "_wb_rd"}, 32'(o_wb_rd), 32'd0);
    chk({tag, "_wb_data"}, o_wb_data, 32'd0);
  endtask

  initial begin
    int n;
    i_rst_n     = 1'b1;
    i_req_valid = 1'b0;
    i_req_op    = '0;
    i_req_func  = '0;
    i_req_rs1   = '0;
    i_req_rs2   = '0;
    i_req_rd    = '0;
    i_wb_ready  = 1'b1;
    #2 i_rst_n = 1'b0;
    #3 check_reset_outputs("reset");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // ADD 5+3 -> rd 7, cycle-exact
    send(3'b000, 2'b00, 32'd5, 32'd3, 5'd7);
    @(negedge i_clk);
    chk("add_c2_start", 32'(o_au_start), 32'd0);
    chk("add_c2_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    chk("add_c3_wb_valid", 32'(o_wb_valid), 32'd0);
    chk("add_c3_rs1_held", o_au_rs1, 32'd5);
    @(negedge i_clk);
    chk("add_c4_wb_valid", 32'(o_wb_valid), 32'd1);
    chk("add_c4_req_ready", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    chk("add_c5_req_ready", 32'(o_req_ready), 32'd1);
    chk("add_c5_wb_valid", 32'(o_wb_valid), 32'd0);

    // rd=0: write dropped, ready again in cycle 4
    send(3'b000, 2'b00, 32'd1, 32'd1, 5'd0);
    @(negedge i_clk);
    chk("rd0_c2_wb_valid", 32'(o_wb_valid), 32'd0);
    @(negedge i_clk);
    chk("rd0_c3_wb_valid", 32'(o_wb_valid), 32'd0);
    @(negedge i_clk);
    chk("rd0_c4_req_ready", 32'(o_req_ready), 32'd1);
    chk("rd0_c4_wb_valid", 32'(o_wb_valid), 32'd0);

    // SUB 0-1 under backpressure, with a competing request that must be ignored
    i_wb_ready = 1'b0;
    send(3'b000, 2'b01, 32'd0, 32'd1, 5'd2);
    n = 0;
    while (!o_wb_valid && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("bp_wb_valid_rise", 32'(o_wb_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b1;
      i_req_op    = 3'b000;
      i_req_func  = 2'b00;
      i_req_rs1   = 32'hAA;
      i_req_rs2   = 32'hBB;
      i_req_rd    = 5'd9;
      @(negedge i_clk);
      chk("bp_wb_valid", 32'(o_wb_valid), 32'd1);
      chk("bp_wb_data", o_wb_data, 32'hFFFF_FFFF);
      chk("bp_wb_rd", 32'(o_wb_rd), 32'd2);
      chk("bp_req_ready", 32'(o_req_ready), 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_wb_ready  = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("bp_done_busy", 32'(o_busy), 32'd0);
    chk("bp_ignored_rs1", o_au_rs1, 32'd0);
    @(negedge i_clk);
    chk("bp_no_start", 32'(o_busy), 32'd0);

    send(3'b000, 2'b01, 32'd9, 32'd4, 5'd2);
    wait_idle(50);

    // Unsupported op: the unit never answers
    send(3'b001, 2'b00, 32'd7, 32'd7, 5'd4);
`ifdef ARITH_DISPATCH_TIMEOUT_EN
    n = 1;
    while (o_busy && n < 100) begin
      @(negedge i_clk);
      if (o_busy) n++;
    end
    chk("timeout_busy_cycles", 32'(n), 32'd17);
    chk("timeout_err", 32'(o_err), 32'd1);
    send(3'b000, 2'b00, 32'd2, 32'd3, 5'd1);
    wait_idle(50);
    chk("timeout_err_sticky", 32'(o_err), 32'd1);
`else
    n = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge i_clk);
      if (o_busy) n++;
    end
    chk("hang_busy_cycles", 32'(n), 32'd110);
    chk("hang_err", 32'(o_err), 32'd0);
`endif
    #1 i_rst_n = 1'b0;
    #1 check_reset_outputs("rst_hang");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Reset in WAIT loses the op; a later ADD works normally
    au_lat = 5;
    send(3'b000, 2'b00, 32'd2, 32'd2, 5'd3);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("rst_wait");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    au_lat = 0;
    repeat (10) @(negedge i_clk);
    chk("rst_wait_idle", 32'(o_busy), 32'd0);
    send(3'b000, 2'b00, 32'd2, 32'd2, 5'd3);
    wait_idle(50);

    // Randomized ADD/SUB with random latency and backpressure
    wb_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      au_lat = $urandom_range(0, 3);
      send(3'b000, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    end
    wait_idle(200);
    wb_rand = 1'b0;
    @(posedge i_clk);
    #2 i_wb_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arith_dispatch.md
# arith_dispatch

Issue-side initiator for the arithmetic unit. It accepts one decoded arithmetic request at a time over a valid/ready handshake and drives the unit's start/operand interface, holding operands stable until the unit responds. It then captures the result and presents it on a valid/ready writeback port to the register file. It sits between decode and the arithmetic unit in the execute stage.

## Interface
- XLEN, 32, datapath width
- TIMEOUT_CYCLES, 16, WAIT-state cycle limit (used only with ARITH_DISPATCH_TIMEOUT_EN); legal range 2..255
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_req_valid  in  1  request valid from decode
- o_req_ready  out  1  dispatcher can accept a request
- i_req_op  in  3  arithmetic op code (ADD = 3'b000)
- i_req_func  in  2  function bits; [0]=1 selects subtract
- i_req_rs1, i_req_rs2  in  XLEN  operands
- i_req_rd  in  5  destination register index
- o_au_start  out  1  one-cycle start pulse to the unit
- o_au_op  out  3  op to the unit
- o_au_func  out  2  func to the unit
- o_au_rs1, o_au_rs2  out  XLEN  operands to the unit
- i_au_valid  in  1  unit valid
- i_au_result  in  XLEN  unit result
- o_wb_valid  out  1  writeback valid
- i_wb_ready  in  1  register file accepts writeback
- o_wb_rd  out  5  writeback destination
- o_wb_data  out  XLEN  writeback data
- o_busy  out  1  high whenever state != IDLE
- o_err  out  1  sticky timeout flag (constant 0 without macro)

## Operation
- States: IDLE, START, WAIT, CAPTURE, WB.
- IDLE: o_req_ready=1. On i_req_valid: latch op, func, rs1, rs2, rd into holding registers and go to START. No other state accepts requests.
- START: o_au_start=1 for exactly this cycle. Go to WAIT.
- WAIT: o_au_start=0. When i_au_valid=1, go to CAPTURE.
- CAPTURE: register i_au_result into the result register at the end of the cycle.
  - If the latched rd==0, go to IDLE. The write is dropped and o_wb_valid never asserts.
  - Otherwise go to WB.
- WB: o_wb_valid=1, with o_wb_rd and o_wb_data held stable. On i_wb_ready, go to IDLE. Backpressure is unbounded.
- o_au_op, o_au_func, o_au_rs1 and o_au_rs2 are driven from the holding registers at all times. They are stable from START through CAPTURE, as the unit requires operands to be held through the cycle after its valid.
- Arithmetic is done entirely by the unit and is mod 2^XLEN. The dispatcher does not modify data.
- o_busy = (state != IDLE).

## Timing
- Reset values:
  - state = IDLE
  - o_req_ready=1, o_au_start=0, o_wb_valid=0, o_busy=0, o_err=0
  - all holding, result and rd registers = 0; o_au_op=3'b000
- Cycle-level sequence, where cycle 0 is the handshake cycle:
  - cycle 0: handshake in IDLE
  - cycle 1: START
  - cycle 2: WAIT, with the unit's i_au_valid high
  - cycle 3: CAPTURE
  - cycle 4: WB, o_wb_valid=1
- With i_wb_ready=1 in cycle 4, the earliest next accept is cycle 5. Throughput is one op per 5 cycles.
- A longer unit latency extends WAIT by the same number of cycles.
- i_au_valid is ignored outside WAIT.
- Reset mid-operation (any state) returns immediately to IDLE with reset values. The in-flight op is lost and no writeback is issued.

## Configuration
- ARITH_DISPATCH_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without i_au_valid.
  - When it reaches TIMEOUT_CYCLES, go to IDLE with no writeback and set o_err. o_err stays set until reset.
  - This covers unsupported ops, which the unit never acknowledges.
- Undefined: no counter. WAIT waits indefinitely and o_err is tied to 0.

## Test plan
- ADD: op=000, func=00, rs1=5, rs2=3, rd=7 -> one o_au_start pulse in cycle 1; o_wb_valid in cycle 4 with rd=7, data=8; o_req_ready=1 again in cycle 5.
- SUB wrap: func=01, rs1=0, rs2=1, rd=2 -> data=32'hFFFF_FFFF; a second SUB with rs1=9, rs2=4 -> data=5.
- rd=0: ADD 1+1, rd=0 -> o_wb_valid never rises; o_req_ready returns 1 in cycle 4.
- Backpressure: hold i_wb_ready=0 for 3 cycles in WB -> o_wb_valid, rd and data stable; o_req_ready=0 and new i_req_valid is ignored; completes on the first ready cycle.
- Timeout (macro on, TIMEOUT_CYCLES=16): op=3'b001 -> no i_au_valid; after 16 WAIT cycles return to IDLE, o_err=1 sticky, no writeback. With the macro off: o_busy stays 1 for more than 100 cycles.
- Reset mid-WAIT: deassert i_rst_n in cycle 2 -> all outputs at reset values immediately; a later ADD 2+2 writes back 4 normally.
